// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the input conditioner.
// The master side drives the raw lines; the slave side is the conditioner itself.
interface input_conditioner_if;
  logic btn_n_raw;
  logic sw1_raw;
  logic sw2_raw;
  logic btn_level;
  logic btn_click;
  logic btn_release;
  logic btn_repeat;
  logic sw1;
  logic sw2;
  logic sw_change;

  modport master (
    output btn_n_raw, sw1_raw, sw2_raw,
    input  btn_level, btn_click, btn_release, btn_repeat, sw1, sw2, sw_change
  );

  modport slave (
    input  btn_n_raw, sw1_raw, sw2_raw,
    output btn_level, btn_click, btn_release, btn_repeat, sw1, sw2, sw_change
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces one active-low pushbutton and two slide switches,
// producing clean levels plus click / release / auto-repeat / switch-change pulses.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_RATE     = 10_000_000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input_conditioner_if.slave   io
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    REPEAT = 2'b10
  } btn_state_t;

  // Channel 0 = button (1 = pressed), 1 = switch 1, 2 = switch 2.
  logic [2:0]       raw_vec;
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [2:0]       stable;
  logic [2:0]       stable_q;
  logic [CNT_W-1:0] deb_cnt [3];

  logic             click_q;
  logic             release_q;
  logic             repeat_q;
  logic             sw_change_q;

  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic             repeat_nxt;
  logic             press_evt;

  assign raw_vec = {io.sw2_raw, io.sw1_raw, ~io.btn_n_raw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_vec;
      sync_b <= sync_a;
    end
  end

  // Terminal compare uses >= so a counter can only ever clear, never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync_b[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] >= DEB_LAST) begin
          stable[i]  <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign press_evt = stable[0] & ~stable_q[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q    <= '0;
      click_q     <= 1'b0;
      release_q   <= 1'b0;
      sw_change_q <= 1'b0;
    end else begin
      stable_q    <= stable;
      click_q     <= press_evt;
      release_q   <= ~stable[0] & stable_q[0];
      sw_change_q <= |(stable[2:1] ^ stable_q[2:1]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      repeat_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      repeat_q <= repeat_nxt;
    end
  end

  // Release is checked before the terminal count so a repeat never lands on the release.
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    repeat_nxt = 1'b0;
    case (state)
      IDLE: begin
        hold_nxt = '0;
        if (press_evt) state_nxt = HOLD;
      end
      HOLD: begin
        if (!stable[0]) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else if (hold_cnt >= DELAY_LAST) begin
          state_nxt  = REPEAT;
          hold_nxt   = '0;
          repeat_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!stable[0]) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else if (hold_cnt >= RATE_LAST) begin
          hold_nxt   = '0;
          repeat_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  assign io.btn_level   = stable[0];
  assign io.sw1         = stable[1];
  assign io.sw2         = stable[2];
  assign io.btn_click   = click_q;
  assign io.btn_release = release_q;
  assign io.btn_repeat  = repeat_q;
  assign io.sw_change   = sw_change_q;

endmodule
